// File: rtl/load_imm_extract_stage_pkg.sv
// Shared definitions for the load immediate extract stage: operand source
// encodings, immediate format encodings, occupancy states and the 32-bit
// immediate decoder used by the imm_gen sub-module.
package load_imm_extract_stage_pkg;

  localparam int DEF_NUM_SRC = 2;
  localparam int DEF_XLEN    = 64;
  localparam int DEF_TAG_W   = 8;
  localparam int PREG_W      = 6;
  localparam int IMM_W       = 20;

  typedef enum logic [1:0] {
    SRC_REG  = 2'd0,
    SRC_IMM  = 2'd1,
    SRC_FP   = 2'd2,
    SRC_ZERO = 2'd3
  } src_type_e;

  typedef enum logic [2:0] {
    IMM_I        = 3'd0,
    IMM_S        = 3'd1,
    IMM_U        = 3'd2,
    IMM_LUI_PACK = 3'd3
  } imm_type_e;

  // EMPTY: nothing held; ONE: main entry valid; FULL: main and skid valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Every format reduces to a 32-bit value whose bit 31 is the sign, so the
  // caller only has to sign-extend that to the operand width. I/S are
  // pre-extended from bit 11 here; reserved formats decode to zero.
  function automatic logic [31:0] imm_decode(
    input logic [2:0]        imm_type,
    input logic [IMM_W-1:0]  imm,
    input logic [PREG_W-1:0] psrc0,
    input logic [PREG_W-1:0] psrc1
  );
    logic [31:0] v;
    v = '0;
    case (imm_type)
      IMM_I, IMM_S: v = {{20{imm[11]}}, imm[11:0]};
      IMM_U:        v = {imm, 12'h000};
      // Compressed LUI spreads its 20-bit payload over both psrc fields.
      IMM_LUI_PACK: v = {psrc1, psrc0, imm[19:12], 12'h000};
      default:      v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/load_imm_extract_stage_if.sv
// Bundle of the issue-side and function-unit-side handshake signals of the
// load immediate extract stage. The stage itself uses the slave view.
interface load_imm_extract_stage_if
  import load_imm_extract_stage_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int XLEN    = DEF_XLEN,
  parameter int TAG_W   = DEF_TAG_W
);

  logic                      in_valid;
  logic                      in_ready;
  logic [2*NUM_SRC-1:0]      in_src_type;
  logic [2:0]                in_imm_type;
  logic [IMM_W-1:0]          in_imm;
  logic [PREG_W*NUM_SRC-1:0] in_psrc;
  logic [XLEN*NUM_SRC-1:0]   in_data;
  logic [TAG_W-1:0]          in_tag;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN*NUM_SRC-1:0]   out_data;
  logic [TAG_W-1:0]          out_tag;

  // Producer of uops / consumer of resolved operands.
  modport master (
    output in_valid, in_src_type, in_imm_type, in_imm, in_psrc, in_data,
           in_tag, flush, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  // The extract stage.
  modport slave (
    input  in_valid, in_src_type, in_imm_type, in_imm, in_psrc, in_data,
           in_tag, flush, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );

endinterface

// File: rtl/load_imm_extract_stage_imm_gen.sv
// Combinational immediate generator shared by all operand slots: decodes
// the packed immediate (plus psrc0/psrc1 for compressed LUI) to XLEN bits.
module load_imm_extract_stage_imm_gen
  import load_imm_extract_stage_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [2:0]        imm_type,
  input  logic [IMM_W-1:0]  imm,
  input  logic [PREG_W-1:0] psrc0,
  input  logic [PREG_W-1:0] psrc1,
  output logic [XLEN-1:0]   imm_val
);

  logic [31:0] imm32;

  // Decode to 32 bits, then sign-extend from bit 31 to the operand width.
  always_comb begin
    imm32   = imm_decode(imm_type, imm, psrc0, psrc1);
    imm_val = XLEN'($signed(imm32));
  end

endmodule

// File: rtl/load_imm_extract_stage.sv
// Load immediate extract stage: resolves each operand slot of an issuing
// uop to register data, the decoded immediate or zero, and registers the
// result behind a two-entry valid/ready skid buffer with flush.
module load_imm_extract_stage
  import load_imm_extract_stage_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int XLEN    = DEF_XLEN,
  parameter int TAG_W   = DEF_TAG_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  load_imm_extract_stage_if.slave  bus
);

  logic [XLEN-1:0]         imm_val;
  logic [NUM_SRC*XLEN-1:0] in_operands;

  occ_e                    state;
  logic                    out_valid_q;
  logic                    in_ready_q;
  logic [NUM_SRC*XLEN-1:0] main_data;
  logic [TAG_W-1:0]        main_tag;
  logic [NUM_SRC*XLEN-1:0] skid_data;
  logic [TAG_W-1:0]        skid_tag;

  logic in_fire;
  logic out_fire;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;

  load_imm_extract_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .imm_type (bus.in_imm_type),
    .imm      (bus.in_imm),
    .psrc0    (bus.in_psrc[PREG_W-1:0]),
    .psrc1    (bus.in_psrc[2*PREG_W-1:PREG_W]),
    .imm_val  (imm_val)
  );

  // Per-slot operand select on the incoming uop.
  // NOTE: combinational blocks use blocking '=' and assign a default first so
  // every path drives every bit and no latch is inferred.
  always_comb begin
    in_operands = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (src_type_e'(bus.in_src_type[2*i +: 2]))
        SRC_REG, SRC_FP: in_operands[XLEN*i +: XLEN] = bus.in_data[XLEN*i +: XLEN];
        SRC_IMM:         in_operands[XLEN*i +: XLEN] = imm_val;
        default:         in_operands[XLEN*i +: XLEN] = '0;
      endcase
    end
  end

  assign in_fire  = bus.in_valid & in_ready_q;
  assign out_fire = out_valid_q & bus.out_ready;

  // Which register captures what this edge; flush only clears valids, so
  // the data paths do not need to look at it.
  assign load_main_in   = in_fire & ((state == OCC_EMPTY) | ((state == OCC_ONE) & out_fire));
  assign load_main_skid = (state == OCC_FULL) & out_fire;
  assign load_skid      = (state == OCC_ONE) & in_fire & ~out_fire;

  // Occupancy FSM with registered out_valid / in_ready; flush dominates.
  // NOTE: sequential state is updated with non-blocking '<=' so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (bus.flush) begin
      state       <= OCC_EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state)
        OCC_EMPTY: begin
          if (in_fire) begin
            state       <= OCC_ONE;
            out_valid_q <= 1'b1;
          end
        end
        OCC_ONE: begin
          if (in_fire && !out_fire) begin
            state      <= OCC_FULL;
            in_ready_q <= 1'b0;
          end else if (!in_fire && out_fire) begin
            state       <= OCC_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        OCC_FULL: begin
          if (out_fire) begin
            state      <= OCC_ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= OCC_EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  // Main entry payload: reset to zero because it drives out_data/out_tag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      main_tag  <= '0;
    end else if (load_main_in) begin
      main_data <= in_operands;
      main_tag  <= bus.in_tag;
    end else if (load_main_skid) begin
      main_data <= skid_data;
      main_tag  <= skid_tag;
    end
  end

  // Skid entry payload, written only when main is stalled.
  // NOTE: pure data storage guarded by a valid bit needs no reset; leaving
  // it out keeps the reset net off these flops.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_data <= in_operands;
      skid_tag  <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_data;
  assign bus.out_tag   = main_tag;

endmodule

// File: tb/tb_load_imm_extract_stage.sv
// Self-checking bench for load_imm_extract_stage: directed vector table,
// hand-written backpressure/stream/flush/reset sequences and random traffic
// scored against a queue-based FIFO model with an arithmetic immediate model.
module tb_load_imm_extract_stage;

  localparam int NUM_SRC = 2;
  localparam int XLEN    = 64;
  localparam int TAG_W   = 8;

  typedef struct {
    logic [127:0]     data;
    logic [TAG_W-1:0] tag;
  } uop_t;

  typedef struct {
    logic [3:0]   src_type;
    logic [2:0]   imm_type;
    logic [19:0]  imm;
    logic [11:0]  psrc;
    logic [127:0] data;
    logic [127:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  uop_t model_q[$];
  vec_t vecs[9];

  load_imm_extract_stage_if #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .TAG_W(TAG_W)) bus ();

  load_imm_extract_stage #(.NUM_SRC(NUM_SRC), .XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Immediate as a signed integer, from the format rules.
  function automatic logic [63:0] ref_imm(input logic [2:0] t, input logic [19:0] imm,
                                          input logic [5:0] p0, input logic [5:0] p1);
    longint v;
    case (t)
      3'd0, 3'd1: begin
        v = longint'(imm[11:0]);
        if (v >= 2048) v = v - 4096;
      end
      3'd2: begin
        v = longint'(imm) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      3'd3: begin
        v = ((longint'(p1) * 64 + longint'(p0)) * 256 + longint'(imm[19:12])) * 4096;
        if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end
      default: v = 0;
    endcase
    return 64'(v);
  endfunction

  function automatic logic [127:0] ref_operands(input logic [3:0] st, input logic [2:0] t,
                                                input logic [19:0] imm, input logic [11:0] psrc,
                                                input logic [127:0] data);
    logic [127:0] r;
    logic [63:0]  iv;
    iv = ref_imm(t, imm, psrc[5:0], psrc[11:6]);
    r  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      case (st[2*i +: 2])
        2'd0, 2'd2: r[64*i +: 64] = data[64*i +: 64];
        2'd1:       r[64*i +: 64] = iv;
        default:    r[64*i +: 64] = 64'h0;
      endcase
    end
    return r;
  endfunction

  // Compare outputs with the model, advance the model by this edge's
  // handshakes, then move to 1 time unit after the next rising edge.
  task automatic cycle();
    bit   m_in_ready;
    uop_t u;
    m_in_ready = (model_q.size() < 2);
    check("out_valid", {127'h0, bus.out_valid}, {127'h0, model_q.size() != 0});
    check("in_ready", {127'h0, bus.in_ready}, {127'h0, m_in_ready});
    if (model_q.size() != 0) begin
      check("out_data", bus.out_data, model_q[0].data);
      check("out_tag", {120'h0, bus.out_tag}, {120'h0, model_q[0].tag});
    end
    if (bus.flush) begin
      model_q.delete();
    end else begin
      if (model_q.size() != 0 && bus.out_ready) void'(model_q.pop_front());
      if (bus.in_valid && m_in_ready) begin
        u.data = ref_operands(bus.in_src_type, bus.in_imm_type, bus.in_imm, bus.in_psrc, bus.in_data);
        u.tag  = bus.in_tag;
        model_q.push_back(u);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] st, input logic [2:0] t,
                       input logic [19:0] imm, input logic [11:0] psrc,
                       input logic [127:0] data, input logic [TAG_W-1:0] tag);
    bus.in_valid    = v;
    bus.in_src_type = st;
    bus.in_imm_type = t;
    bus.in_imm      = imm;
    bus.in_psrc     = psrc;
    bus.in_data     = data;
    bus.in_tag      = tag;
  endtask

  task automatic push_tag(input logic [TAG_W-1:0] tag);
    drive(1'b1, 4'b1010, 3'd0, 20'h0, 12'h0, {64'(tag) + 64'h100, 64'(tag)}, tag);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive(1'b0, '0, '0, '0, '0, '0, '0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    vecs[0] = '{4'b0001, 3'd3, 20'h12000, 12'hFC0, {64'h1111, 64'h5555},
                {64'h1111, 64'hFFFFFFFF_FC012000}};
    vecs[1] = '{4'b0100, 3'd0, 20'h00800, 12'h000, {64'h9999, 64'hDEAD},
                {64'hFFFFFFFF_FFFFF800, 64'h0000_DEAD}};
    vecs[2] = '{4'b1101, 3'd2, 20'h80000, 12'h000, {64'h77, 64'h88},
                {64'h0, 64'hFFFFFFFF_80000000}};
    vecs[3] = '{4'b0101, 3'd1, 20'hAB7FF, 12'h000, {64'h1, 64'h2},
                {64'h7FF, 64'h7FF}};
    vecs[4] = '{4'b0101, 3'd5, 20'h12345, 12'h3C5, {64'h1, 64'h2},
                {64'h0, 64'h0}};
    vecs[5] = '{4'b1010, 3'd0, 20'hFFFFF, 12'hFFF, {64'hCAFEBABE_00000001, 64'h01234567_89ABCDEF},
                {64'hCAFEBABE_00000001, 64'h01234567_89ABCDEF}};
    vecs[6] = '{4'b0111, 3'd3, 20'h45000, 12'h063, {64'h5, 64'h6},
                {64'h06345000, 64'h0}};
    vecs[7] = '{4'b0001, 3'd2, 20'h7FFFF, 12'h000, {64'h42, 64'h0},
                {64'h42, 64'h7FFFF000}};
    vecs[8] = '{4'b0001, 3'd1, 20'h00FFF, 12'h000, {64'h3, 64'h0},
                {64'h3, 64'hFFFFFFFF_FFFFFFFF}};

    // Reset state.
    #12;
    check("rst_out_valid", {127'h0, bus.out_valid}, 128'h0);
    check("rst_in_ready", {127'h0, bus.in_ready}, 128'h1);
    check("rst_out_data", bus.out_data, 128'h0);
    check("rst_out_tag", {120'h0, bus.out_tag}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle();

    // Directed decode vectors, one uop at a time.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].src_type, vecs[i].imm_type, vecs[i].imm, vecs[i].psrc,
            vecs[i].data, TAG_W'(i));
      cycle();
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {127'h0, bus.out_valid}, 128'h1);
      check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp);
      cycle();
    end

    // Backpressure: A then B while stalled, C waits for in_ready.
    bus.out_ready = 1'b0;
    push_tag(8'hA1);
    cycle();
    push_tag(8'hB2);
    cycle();
    bus.in_valid = 1'b0;
    check("bp_full_in_ready", {127'h0, bus.in_ready}, 128'h0);
    check("bp_head_a", {120'h0, bus.out_tag}, {120'h0, 8'hA1});
    cycle();
    check("bp_hold_a", {120'h0, bus.out_tag}, {120'h0, 8'hA1});
    bus.out_ready = 1'b1;
    push_tag(8'hC3);
    cycle();
    check("bp_head_b", {120'h0, bus.out_tag}, {120'h0, 8'hB2});
    check("bp_ready_back", {127'h0, bus.in_ready}, 128'h1);
    cycle();
    check("bp_head_c", {120'h0, bus.out_tag}, {120'h0, 8'hC3});
    bus.in_valid = 1'b0;
    cycle();
    cycle();

    // Streaming: 10 back-to-back uops, no bubbles.
    bus.out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) push_tag(TAG_W'(i));
      else bus.in_valid = 1'b0;
      if (i > 0) begin
        check($sformatf("stream%0d_valid", i - 1), {127'h0, bus.out_valid}, 128'h1);
        check($sformatf("stream%0d_tag", i - 1), {120'h0, bus.out_tag}, 128'(i - 1));
      end
      cycle();
    end
    cycle();

    // Flush while FULL with a same-cycle push.
    bus.out_ready = 1'b0;
    push_tag(8'h51);
    cycle();
    push_tag(8'h52);
    cycle();
    push_tag(8'h53);
    bus.flush = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_out_valid", {127'h0, bus.out_valid}, 128'h0);
    check("flush_in_ready", {127'h0, bus.in_ready}, 128'h1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    // Asynchronous reset while FULL.
    bus.out_ready = 1'b0;
    push_tag(8'h61);
    cycle();
    push_tag(8'h62);
    cycle();
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", {127'h0, bus.out_valid}, 128'h0);
    check("arst_in_ready", {127'h0, bus.in_ready}, 128'h1);
    check("arst_out_data", bus.out_data, 128'h0);
    model_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    cycle();
    drive(1'b1, vecs[0].src_type, vecs[0].imm_type, vecs[0].imm, vecs[0].psrc,
          vecs[0].data, 8'h77);
    cycle();
    bus.in_valid = 1'b0;
    check("arst_push_data", bus.out_data, vecs[0].exp);
    check("arst_push_tag", {120'h0, bus.out_tag}, {120'h0, 8'h77});
    cycle();
    cycle();

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive(1'b0 == ($urandom_range(0, 3) == 0),
            4'($urandom), 3'($urandom_range(0, 7)), 20'($urandom), 12'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, TAG_W'($urandom));
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_imm_extract_stage.md
# load_imm_extract_stage

Registered, multi-source successor to the combinational load immediate extractor. For each of NUM_SRC operand slots of an issuing uop, it selects between the register-file read data and an immediate decoded from the uop's packed fields. Supported immediate formats are I, S, U and the compressed load-LUI form, which is packed across imm and psrc. The block sits between the reservation-station data array read and the load/store function unit, behind a two-entry valid/ready skid buffer, with flush support.

## Interface
- NUM_SRC, 2, operand slots per uop (≥2 when LUI_PACK is used)
- XLEN, 64, operand data width
- PREG_W, 6, physical register index width; LUI_PACK requires 2*PREG_W+8 = 20
- TAG_W, 8, opaque sideband (robIdx etc.) carried with the uop
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream uop valid
- in_ready  out  1  stage can accept
- in_srcType  in  2*NUM_SRC  per-slot type: 0 int reg, 1 imm, 2 fp reg, 3 zero
- in_immType  in  3  0 I, 1 S, 2 U, 3 LUI_PACK, others reserved
- in_imm  in  20  packed immediate field
- in_psrc  in  PREG_W*NUM_SRC  physical source indices (slot 0 LSB)
- in_data  in  XLEN*NUM_SRC  register-read data (slot 0 LSB)
- in_tag  in  TAG_W  sideband
- flush  in  1  kill all held and incoming uops
- out_valid  out  1  downstream uop valid
- out_ready  in  1  downstream can accept
- out_data  out  XLEN*NUM_SRC  resolved operands
- out_tag  out  TAG_W  sideband

## Operation
- Per slot i, data select:
  - srcType 0 or 2: in_data[i]
  - srcType 1: imm64
  - srcType 3: 0
- imm64 decode:
  - I: sext(in_imm[11:0])
  - S: sext(in_imm[11:0])
  - U: sext({in_imm[19:0], 12'h0})
  - LUI_PACK: sext({psrc[1], psrc[0], in_imm[19:12], 12'h0}), 32-bit value with bit 31 as sign
  - reserved immType: imm64 = 0
- Sign extension is from bit 31 for U/LUI_PACK and bit 11 for I/S, up to XLEN.
- Decode is combinational on the input side. The result is captured into the output register (main) or the skid register.
- Storage: main entry {valid, data, tag} drives out_*; skid entry holds one uop when main is stalled.
- Occupancy states:
  - EMPTY: main invalid, skid invalid
  - ONE: main valid
  - FULL: main valid, skid valid
- Transitions:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready
  - EMPTY + in_fire → ONE
  - ONE + in_fire & out_fire → ONE (main reloads)
  - ONE + in_fire & !out_fire → FULL (uop to skid)
  - ONE + !in_fire & out_fire → EMPTY
  - FULL + out_fire → ONE (skid moves to main)
- in_ready = !skid.valid; registered, no combinational path from out_ready.
- Ordering is strictly FIFO.
- Flush: next edge clears both valids. The same-cycle in_fire is dropped. Flush dominates every transition.

## Timing
- Reset: main.valid = 0, skid.valid = 0, out_valid = 0, in_ready = 1. out_data and out_tag are 0.
- Latency: 1 cycle, input edge to out_valid, when not FULL.
- Throughput: 1 uop/cycle with out_ready held high.
- in_ready deasserts the cycle after entering FULL. It reasserts the cycle after the FULL → ONE transition.
- Reset asserted mid-transfer: all valids clear immediately (asynchronous), with no out_valid glitch after deassertion.
- out_data and out_tag are stable while out_valid & !out_ready.

## Structure
- Shared package holds the srcType encodings (SRC_REG = 0, SRC_IMM = 1, SRC_FP = 2, SRC_ZERO = 3), the immType encodings, and an imm_decode function.
- Sub-module imm_gen: combinational decode of {immType, imm, psrc0, psrc1} to XLEN. It is instantiated once, since the immediate is shared by all slots.
- Top level: per-slot mux plus skid-buffer control.

## Test plan
- LUI_PACK: srcType0 = 1, psrc1 = 0x3F, psrc0 = 0x00, imm[19:12] = 0x12 → slot0 = 0xFFFFFFFF_FC012000 one cycle later.
- I: imm[11:0] = 0x800, slot1 srcType = 1, slot0 srcType = 0 with data 0xDEAD → out = {0xFFFFFFFFFFFFF800, 0xDEAD}. U: imm = 0x80000 → 0xFFFFFFFF80000000.
- Backpressure: out_ready = 0, push A then B → out shows A, in_ready = 0 after B. Then out_ready = 1 → A, then B, in order; a third push C is accepted only after in_ready returns to 1.
- Streaming: in_valid = out_ready = 1 for 10 cycles with incrementing tag → 10 outputs, tags 0..9, no bubbles.
- Flush while FULL, with a new in_valid the same cycle → next cycle out_valid = 0, in_ready = 1, and no stale uop ever emitted.
- Reset asserted asynchronously while FULL → out_valid = 0 immediately; after release, a single push emerges correctly.
